keycode_arbiter: RTL and testbench

- Sits directly upstream of the ball motion block and drives its 8-bit keycode input.
- Accepts 6-slot USB HID boot-keyboard reports from the USB/MicroBlaze side through a valid/ready handshake and tracks which movement keys (W/A/S/D) are held.
- Resolves them to one active direction keycode and presents it frame-synchronously, so the ball stage sees one stable keycode per frame.

---
 rtl/keycode_arbiter_if.sv | 9 +
 rtl/keycode_arbiter.sv | 177 +++++++++++++++++
 tb/tb_keycode_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keycode_arbiter_if.sv
// Report handshake bus between the USB/MicroBlaze producer and keycode_arbiter.
interface keycode_arbiter_if;
    logic        report_valid;
    logic [47:0] report_data;
    logic        report_ready;

    modport master (output report_valid, output report_data, input report_ready);
    modport slave  (input report_valid, input report_data, output report_ready);
endinterface

// File: rtl/keycode_arbiter.sv
// Resolves HID boot-keyboard reports into one W/A/S/D direction keycode, updated per frame.
// Optional KEYARB_TIMEOUT_EN clears held keys after TIMEOUT_FRAMES frames without a report.
module keycode_arbiter #(
    parameter logic [7:0] KEY_W = 8'h1A,
    parameter logic [7:0] KEY_A = 8'h04,
    parameter logic [7:0] KEY_S = 8'h16,
    parameter logic [7:0] KEY_D = 8'h07
`ifdef KEYARB_TIMEOUT_EN
    ,
    parameter logic [7:0] TIMEOUT_FRAMES = 8'd30
`endif
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    keycode_arbiter_if.slave        rpt,
    input  logic                    frame_tick,
    output logic [7:0]              keycode_out,
    output logic                    scan_busy
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_COMMIT = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [3:0]  held_q, held_d;
    logic [3:0]  new_held_q, new_held_d;
    logic [7:0]  new_press_q, new_press_d;
    logic        discard_q, discard_d;
    logic [7:0]  active_q, active_d;
    logic [7:0]  keycode_out_q, keycode_out_d;
    logic [2:0]  idx_q, idx_d;
    logic [47:0] data_q, data_d;
    logic        scan_busy_q;
    logic        accept_s;
    logic        timeout_s;
    logic [7:0]  slot_s;
    logic [3:0]  slot_bit_s;

    // Bit order of the held sets: [0]=W, [1]=A, [2]=S, [3]=D.
    function automatic logic [3:0] key_bit(input logic [7:0] code);
        logic [3:0] b;
        case (code)
            KEY_W:   b = 4'b0001;
            KEY_A:   b = 4'b0010;
            KEY_S:   b = 4'b0100;
            KEY_D:   b = 4'b1000;
            default: b = 4'b0000;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] prio_key(input logic [3:0] h);
        logic [7:0] k;
        if (h[0])      k = KEY_W;
        else if (h[1]) k = KEY_A;
        else if (h[2]) k = KEY_S;
        else if (h[3]) k = KEY_D;
        else           k = 8'h00;
        return k;
    endfunction

    assign rpt.report_ready = (state_q == ST_IDLE) && Reset_n;
    assign accept_s         = rpt.report_valid && rpt.report_ready;
    assign slot_s           = data_q[{idx_q, 3'b000} +: 8];
    assign slot_bit_s       = key_bit(slot_s);
    assign keycode_out      = keycode_out_q;
    assign scan_busy        = scan_busy_q;

`ifdef KEYARB_TIMEOUT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Frame counter since the last accepted report, saturating at the timeout.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (accept_s) begin
            frame_cnt_d = 8'd0;
        end else if (frame_tick && (frame_cnt_q < TIMEOUT_FRAMES)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        timeout_s = (state_q == ST_IDLE) && !accept_s && (frame_cnt_d == TIMEOUT_FRAMES);
    end

    // Frame counter register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) frame_cnt_q <= 8'd0;
        else          frame_cnt_q <= frame_cnt_d;
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic: report latch, per-slot scan, commit of the resolved direction.
    always_comb begin
        state_d       = state_q;
        held_d        = held_q;
        new_held_d    = new_held_q;
        new_press_d   = new_press_q;
        discard_d     = discard_q;
        active_d      = active_q;
        idx_d         = idx_q;
        data_d        = data_q;
        keycode_out_d = frame_tick ? active_q : keycode_out_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d      = rpt.report_data;
                    new_held_d  = 4'b0000;
                    new_press_d = 8'h00;
                    discard_d   = 1'b0;
                    idx_d       = 3'd0;
                    state_d     = ST_SCAN;
                end else if (timeout_s) begin
                    held_d   = 4'b0000;
                    active_d = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (slot_bit_s != 4'b0000) begin
                    new_held_d = new_held_q | slot_bit_s;
                    // Later slots overwrite, so the highest slot index wins.
                    if ((held_q & slot_bit_s) == 4'b0000) new_press_d = slot_s;
                    else                                   new_press_d = new_press_q;
                end else if (slot_s == 8'h01) begin
                    discard_d = 1'b1;
                end else begin
                    new_held_d = new_held_q;
                end
                if (idx_q == 3'd5) state_d = ST_COMMIT;
                else               idx_d   = idx_q + 3'd1;
            end
            ST_COMMIT: begin
                if (discard_q) begin
                    held_d = held_q;
                end else begin
                    held_d = new_held_q;
                    if (new_press_q != 8'h00)                          active_d = new_press_q;
                    else if ((key_bit(active_q) & new_held_q) != 4'b0) active_d = active_q;
                    else                                               active_d = prio_key(new_held_q);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            held_q        <= 4'b0000;
            new_held_q    <= 4'b0000;
            new_press_q   <= 8'h00;
            discard_q     <= 1'b0;
            active_q      <= 8'h00;
            keycode_out_q <= 8'h00;
            idx_q         <= 3'd0;
            data_q        <= 48'h0;
            scan_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            new_held_q    <= new_held_d;
            new_press_q   <= new_press_d;
            discard_q     <= discard_d;
            active_q      <= active_d;
            keycode_out_q <= keycode_out_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            scan_busy_q   <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_keycode_arbiter.sv
// Directed self-checking bench for keycode_arbiter.
module tb_keycode_arbiter;
    logic       Clk;
    logic       Reset_n;
    logic       frame_tick;
    logic [7:0] keycode_out;
    logic       scan_busy;
    int         checks;
    int         errors;
    int         low_cnt;

    keycode_arbiter_if bus ();

`ifdef KEYARB_TIMEOUT_EN
    keycode_arbiter #(.TIMEOUT_FRAMES(8'd4)) dut (
`else
    keycode_arbiter dut (
`endif
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .rpt         (bus.slave),
        .frame_tick  (frame_tick),
        .keycode_out (keycode_out),
        .scan_busy   (scan_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Waits for ready, hands over one report, then waits out the busy window.
    task automatic send(input logic [47:0] data, input string tag);
        int w;
        w = 0;
        bus.report_valid = 1'b1;
        bus.report_data  = data;
        while (bus.report_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_ready_wait"}, 8'(w < 20), 8'd1);
        step();
        bus.report_valid = 1'b0;
        chk({tag, "_busy"}, {7'd0, scan_busy}, 8'd1);
        low_cnt = 0;
        while (bus.report_ready === 1'b0 && low_cnt < 20) begin
            step();
            low_cnt++;
        end
        chk({tag, "_ready_low_cycles"}, 8'(low_cnt), 8'd7);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        Reset_n          = 1'b0;
        frame_tick       = 1'b0;
        bus.report_valid = 1'b0;
        bus.report_data  = 48'h0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", {7'd0, bus.report_ready}, 8'd0);
        end
        chk("rst_keycode", keycode_out, 8'h00);
        chk("rst_busy", {7'd0, scan_busy}, 8'd0);
        Reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {7'd0, bus.report_ready}, 8'd1);

        // Single W press, visible only after a tick
        send(48'h0000_0000_001A, "w_press");
        chk("w_before_tick", keycode_out, 8'h00);
        chk("idle_busy", {7'd0, scan_busy}, 8'd0);
        tick();
        chk("w_after_tick", keycode_out, 8'h1A);

        // W held, D newly pressed wins; then D released falls back to W
        send(48'h0000_0000_071A, "wd");
        tick();
        chk("new_press_d", keycode_out, 8'h07);
        send(48'h0000_0000_001A, "w_only");
        tick();
        chk("fallback_w", keycode_out, 8'h1A);

        // Release everything
        send(48'h0, "release");
        tick();
        chk("release_none", keycode_out, 8'h00);

        // Two new presses: highest slot wins
        send(48'h0000_0000_1604, "as_new");
        tick();
        chk("highest_slot", keycode_out, 8'h16);

        // ErrorRollOver discards the report
        send(48'h0000_0100_0000, "rollover");
        tick();
        chk("rollover_keep", keycode_out, 8'h16);
        // Held set {A,S} must have survived: neither key counts as new here
        send(48'h0000_0000_0416, "held_kept");
        tick();
        chk("held_kept", keycode_out, 8'h16);

        // Tick on the commit edge sees the pre-commit active value
        send(48'h0, "clear2");
        tick();
        chk("clear2", keycode_out, 8'h00);
        bus.report_valid = 1'b1;
        bus.report_data  = 48'h0000_0000_001A;
        step();
        bus.report_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_commit_busy", {7'd0, scan_busy}, 8'd1);
        tick();
        chk("commit_tick", keycode_out, 8'h00);
        chk("commit_ready", {7'd0, bus.report_ready}, 8'd1);
        tick();
        chk("commit_next_tick", keycode_out, 8'h1A);

        // Reset mid-scan abandons the report
        bus.report_valid = 1'b1;
        bus.report_data  = 48'h0000_0000_0007;
        step();
        bus.report_valid = 1'b0;
        step();
        step();
        Reset_n = 1'b0;
        step();
        chk("midscan_rst_busy", {7'd0, scan_busy}, 8'd0);
        chk("midscan_rst_ready", {7'd0, bus.report_ready}, 8'd0);
        chk("midscan_rst_key", keycode_out, 8'h00);
        Reset_n = 1'b1;
        tick();
        chk("midscan_rst_tick", keycode_out, 8'h00);

        // D press followed by ten idle frames
        send(48'h0000_0000_0007, "d_press");
        for (int i = 1; i <= 10; i++) begin
            tick();
`ifdef KEYARB_TIMEOUT_EN
            chk($sformatf("timeout_tick%0d", i), keycode_out, (i <= 4) ? 8'h07 : 8'h00);
`else
            chk($sformatf("persist_tick%0d", i), keycode_out, 8'h07);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
